mem_wb_stage: RTL and testbench

MEM/WB pipeline stage of the pipelined LC-3b datapath, directly upstream of the register file. Each cycle it captures the instruction leaving the memory stage and selects the writeback value: ALU result, memory word, sign-extended memory byte, or link PC. It drives the register file's load/dest/in port. It also owns the architectural NZP condition-code register and a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 134 +++++++++++++
 tb/tb_mem_wb_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage of the LC-3b datapath.
// Selects writeback data and owns the NZP register and retired counter.
module mem_wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_ld_regfile,
    input  logic        in_ld_cc,
    input  logic [2:0]  in_dest,
    input  logic [1:0]  in_wbsel,
    input  logic [15:0] in_alu,
    input  logic [15:0] in_mem,
    input  logic [15:0] in_pc,
    input  logic        in_addr_lsb,
    output logic        regfile_load,
    output logic [2:0]  regfile_dest,
    output logic [15:0] regfile_in,
    output logic        wb_valid,
    output logic [2:0]  nzp,
    output logic [15:0] retired
);

    logic        valid_q, valid_d;
    logic        ld_rf_q, ld_rf_d;
    logic        ld_cc_q, ld_cc_d;
    logic [2:0]  dest_q, dest_d;
    logic [1:0]  wbsel_q, wbsel_d;
    logic [15:0] alu_q, alu_d;
    logic [15:0] mem_q, mem_d;
    logic [15:0] pc_q, pc_d;
    logic        lsb_q, lsb_d;
    logic [2:0]  nzp_q, nzp_d;
    logic [15:0] ret_q, ret_d;
    logic [7:0]  byte_lane;
    logic [15:0] wb_data;

    // Next stage contents: flush kills the incoming op, stall holds.
    always_comb begin
        valid_d = valid_q;
        ld_rf_d = ld_rf_q;
        ld_cc_d = ld_cc_q;
        dest_d  = dest_q;
        wbsel_d = wbsel_q;
        alu_d   = alu_q;
        mem_d   = mem_q;
        pc_d    = pc_q;
        lsb_d   = lsb_q;
        if (flush || !stall) begin
            valid_d = in_valid & ~flush;
            ld_rf_d = in_ld_regfile;
            ld_cc_d = in_ld_cc;
            dest_d  = in_dest;
            wbsel_d = in_wbsel;
            alu_d   = in_alu;
            mem_d   = in_mem;
            pc_d    = in_pc;
            lsb_d   = in_addr_lsb;
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ld_rf_q <= 1'b0;
            ld_cc_q <= 1'b0;
            dest_q  <= 3'd0;
            wbsel_q <= 2'd0;
            alu_q   <= 16'h0000;
            mem_q   <= 16'h0000;
            pc_q    <= 16'h0000;
            lsb_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ld_rf_q <= ld_rf_d;
            ld_cc_q <= ld_cc_d;
            dest_q  <= dest_d;
            wbsel_q <= wbsel_d;
            alu_q   <= alu_d;
            mem_q   <= mem_d;
            pc_q    <= pc_d;
            lsb_q   <= lsb_d;
        end
    end

    // Writeback mux, byte loads sign-extended from the addressed lane.
    always_comb begin
        byte_lane = lsb_q ? mem_q[15:8] : mem_q[7:0];
        wb_data   = alu_q;
        unique case (wbsel_q)
            2'd0: wb_data = alu_q;
            2'd1: wb_data = mem_q;
            2'd2: wb_data = {{8{byte_lane[7]}}, byte_lane};
            2'd3: wb_data = pc_q;
        endcase
    end

    // Condition codes and retire count derived from the held op.
    always_comb begin
        if (wb_data[15]) begin
            nzp_d = 3'b100;
        end else if (wb_data == 16'h0000) begin
            nzp_d = 3'b010;
        end else begin
            nzp_d = 3'b001;
        end
        ret_d = ret_q + 16'd1;
    end

    // NZP and retired counter; a held op re-updates NZP harmlessly.
    always_ff @(posedge clk) begin
        if (reset) begin
            nzp_q <= 3'b010;
            ret_q <= 16'h0000;
        end else begin
            if (valid_q && ld_cc_q) begin
                nzp_q <= nzp_d;
            end
            if (valid_q && !stall) begin
                ret_q <= ret_d;
            end
        end
    end

    assign regfile_load = valid_q & ld_rf_q;
    assign regfile_dest = dest_q;
    assign regfile_in   = wb_data;
    assign wb_valid     = valid_q;
    assign nzp          = nzp_q;
    assign retired      = ret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage.
// Table vectors, directed corner cases, random run against a model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        in_valid, in_ld_regfile, in_ld_cc;
    logic [2:0]  in_dest;
    logic [1:0]  in_wbsel;
    logic [15:0] in_alu, in_mem, in_pc;
    logic        in_addr_lsb;
    logic        regfile_load, wb_valid;
    logic [2:0]  regfile_dest, nzp;
    logic [15:0] regfile_in, retired;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit valid;
        bit ldrf;
        bit ldcc;
        int dest;
        int wbsel;
        int alu;
        int mem;
        int pc;
        bit lsb;
    } inst_t;

    typedef struct {
        inst_t op;
        int    exp_in;
        bit    exp_load;
        int    exp_nzp;
    } vec_t;

    inst_t m_op;
    bit    m_known;
    int    m_nzp;
    int    m_ret;

    mem_wb_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ld_regfile(in_ld_regfile),
        .in_ld_cc(in_ld_cc), .in_dest(in_dest), .in_wbsel(in_wbsel),
        .in_alu(in_alu), .in_mem(in_mem), .in_pc(in_pc),
        .in_addr_lsb(in_addr_lsb), .regfile_load(regfile_load),
        .regfile_dest(regfile_dest), .regfile_in(regfile_in),
        .wb_valid(wb_valid), .nzp(nzp), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic int wbval(inst_t o);
        int b;
        case (o.wbsel)
            0: return o.alu;
            1: return o.mem;
            2: begin
                b = o.lsb ? (o.mem / 256) : (o.mem % 256);
                return (b >= 128) ? b + 65280 : b;
            end
            default: return o.pc;
        endcase
    endfunction

    function automatic int ccof(int v);
        if (v >= 32768) return 4;
        if (v == 0) return 2;
        return 1;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(inst_t o);
        in_valid      = o.valid;
        in_ld_regfile = o.ldrf;
        in_ld_cc      = o.ldcc;
        in_dest       = 3'(o.dest);
        in_wbsel      = 2'(o.wbsel);
        in_alu        = 16'(o.alu);
        in_mem        = 16'(o.mem);
        in_pc         = 16'(o.pc);
        in_addr_lsb   = o.lsb;
    endtask

    function automatic inst_t cur_in();
        inst_t o;
        o.valid = in_valid;
        o.ldrf  = in_ld_regfile;
        o.ldcc  = in_ld_cc;
        o.dest  = int'(in_dest);
        o.wbsel = int'(in_wbsel);
        o.alu   = int'(in_alu);
        o.mem   = int'(in_mem);
        o.pc    = int'(in_pc);
        o.lsb   = in_addr_lsb;
        return o;
    endfunction

    function automatic inst_t bubble();
        inst_t o;
        o = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        return o;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_op    = bubble();
            m_known = 1;
            m_nzp   = 2;
            m_ret   = 0;
        end else begin
            if (m_op.valid && m_op.ldcc) m_nzp = ccof(wbval(m_op));
            if (m_op.valid && !stall) m_ret = (m_ret + 1) % 65536;
            if (flush) begin
                m_op.valid = 0;
                m_known    = 0;
            end else if (!stall) begin
                m_op    = cur_in();
                m_known = 1;
            end
        end
    endtask

    task automatic step(bit do_chk);
        @(posedge clk);
        model_edge();
        #1;
        if (do_chk) begin
            chk("m_load", int'(regfile_load), int'(m_op.valid && m_op.ldrf));
            chk("m_valid", int'(wb_valid), int'(m_op.valid));
            chk("m_nzp", int'(nzp), m_nzp);
            chk("m_ret", int'(retired), m_ret);
            if (m_known) begin
                chk("m_dest", int'(regfile_dest), m_op.dest);
                chk("m_in", int'(regfile_in), wbval(m_op));
            end
        end
    endtask

    function automatic inst_t mk(bit v, bit rf, bit cc, int d,
                                 int ws, int a, int m, int p, bit l);
        inst_t o;
        o = '{v, rf, cc, d, ws, a, m, p, l};
        return o;
    endfunction

    vec_t  tbl[7];
    inst_t o;
    int    cyc;

    initial begin
        m_op    = bubble();
        m_known = 0;
        m_nzp   = 2;
        m_ret   = 0;
        reset = 1; stall = 0; flush = 0;
        drive(bubble());

        tbl[0] = '{mk(1,1,1,5,0,'h8001,0,0,0), 'h8001, 1, 4};
        tbl[1] = '{mk(1,1,1,1,2,0,'h7F80,0,0), 'hFF80, 1, 4};
        tbl[2] = '{mk(1,1,1,1,2,0,'h7F80,0,1), 'h007F, 1, 1};
        tbl[3] = '{mk(1,1,1,2,2,0,'h0000,0,1), 'h0000, 1, 2};
        tbl[4] = '{mk(1,1,0,7,3,0,0,'h3002,0), 'h3002, 1, 2};
        tbl[5] = '{mk(1,0,1,2,1,0,'h1234,0,0), 'h1234, 0, 1};
        tbl[6] = '{mk(1,1,1,4,0,0,'hFFFF,0,0), 'h0000, 1, 2};

        step(0);
        chk("rst_load", int'(regfile_load), 0);
        chk("rst_in", int'(regfile_in), 0);
        chk("rst_nzp", int'(nzp), 2);
        chk("rst_ret", int'(retired), 0);
        chk("rst_valid", int'(wb_valid), 0);
        reset = 0;

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].op);
            step(1);
            chk("tbl_load", int'(regfile_load), int'(tbl[i].exp_load));
            chk("tbl_dest", int'(regfile_dest), tbl[i].op.dest);
            chk("tbl_in", int'(regfile_in), tbl[i].exp_in);
            drive(bubble());
            step(1);
            chk("tbl_nzp", int'(nzp), tbl[i].exp_nzp);
            chk("tbl_ret", int'(retired), i + 1);
        end

        drive(mk(1,1,1,3,0,'h1234,0,0,0));
        step(1);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(mk(1,1,1,6,3,0,0,'h4000 + i,0));
            step(1);
            chk("stl_load", int'(regfile_load), 1);
            chk("stl_dest", int'(regfile_dest), 3);
            chk("stl_in", int'(regfile_in), 'h1234);
            chk("stl_ret", int'(retired), 7);
            chk("stl_nzp", int'(nzp), 1);
        end
        stall = 0;
        drive(bubble());
        step(1);
        chk("stl_drop_ret", int'(retired), 8);

        flush = 1;
        drive(mk(1,1,1,1,0,'h55,0,0,0));
        step(1);
        flush = 0;
        drive(bubble());
        chk("fl_valid", int'(wb_valid), 0);
        chk("fl_load", int'(regfile_load), 0);

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            o = mk($urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 3), $urandom_range(0, 65535),
                   $urandom_range(0, 65535), $urandom_range(0, 65535),
                   $urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) o.mem = 0;
            if ($urandom_range(0, 5) == 0) o.alu = 0;
            drive(o);
            step(1);
        end
        reset = 0; stall = 0; flush = 0;

        drive(mk(1,0,0,0,0,1,0,0,0));
        cyc = 0;
        while (m_ret != 'hFFFF && cyc < 70000) begin
            step(0);
            cyc++;
        end
        chk("wrap_pre", int'(retired), 'hFFFF);
        step(1);
        chk("wrap_zero", int'(retired), 0);

        drive(mk(1,1,1,2,0,'h0010,0,0,0));
        step(1);
        stall = 1;
        step(1);
        reset = 1;
        step(1);
        chk("rs_ret", int'(retired), 0);
        chk("rs_valid", int'(wb_valid), 0);
        reset = 0; stall = 0;
        drive(bubble());
        step(1);
        chk("rs_ret2", int'(retired), 0);
        chk("rs_nzp", int'(nzp), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
